// File: rtl/ahb_arbiter.sv
// ahb_arbiter
//   Round-robin AHB bus arbiter with HLOCK hold and a per-owner beat budget.
//   Ports:
//     ahb_clk_in          bus clock, rising edge
//     ahb_rstn_in         synchronous active-low reset
//     ahb_busreq_in       HBUSREQx, one bit per master
//     ahb_lock_in         HLOCKx, one bit per master
//     ahb_trans_in        HTRANS of the current address-phase owner
//     ahb_ready_in        HREADY from the slave mux; all state holds while low
//     ahb_grant_out       HGRANTx, one-hot, registered
//     ahb_master_out      HMASTER, address-phase owner index
//     ahb_master_data_out data-phase owner index
//     ahb_mastlock_out    HMASTLOCK, registered with the address phase
module ahb_arbiter #(
  parameter int unsigned MASTER_DEVICES = 2,
  parameter int unsigned DEFAULT_MASTER = 0,
  parameter int unsigned MAX_HOLD_BEATS = 16,
  parameter int unsigned MW = (MASTER_DEVICES > 2) ? $clog2(MASTER_DEVICES) : 1
) (
  input  logic                      ahb_clk_in,
  input  logic                      ahb_rstn_in,
  input  logic [MASTER_DEVICES-1:0] ahb_busreq_in,
  input  logic [MASTER_DEVICES-1:0] ahb_lock_in,
  input  logic [1:0]                ahb_trans_in,
  input  logic                      ahb_ready_in,
  output logic [MASTER_DEVICES-1:0] ahb_grant_out,
  output logic [MW-1:0]             ahb_master_out,
  output logic [MW-1:0]             ahb_master_data_out,
  output logic                      ahb_mastlock_out
);

  localparam int unsigned CW = $clog2(MAX_HOLD_BEATS + 1);

  localparam logic [1:0] TRANS_IDLE   = 2'b00;
  localparam logic [1:0] TRANS_BUSY   = 2'b01;
  localparam logic [1:0] TRANS_SEQ    = 2'b11;

  localparam logic [MASTER_DEVICES-1:0] DEF_GRANT = MASTER_DEVICES'(1) << DEFAULT_MASTER;
  localparam logic [MW-1:0]             DEF_IDX   = MW'(DEFAULT_MASTER);
  localparam logic [CW-1:0]             CNT_MAX   = CW'(MAX_HOLD_BEATS);

  // Arbitration is resolved in the same edge that leaves PARK/OWN/LOCKED,
  // so there is no separate registered ARB state.
  typedef enum logic [1:0] {
    PARK,
    OWN,
    LOCKED
  } arb_state_t;

  arb_state_t        state;
  logic [MW-1:0]     rr_ptr;
  logic [CW-1:0]     beat_cnt;

  logic [MW-1:0]     gidx;
  logic [MW-1:0]     win_idx;
  logic [MW-1:0]     cand;
  logic              win_found;
  logic              in_burst;
  logic              do_arb;

  // Index of the currently granted master.
  always_comb begin
    gidx = '0;
    for (int unsigned i = 0; i < MASTER_DEVICES; i++) begin
      if (ahb_grant_out[i]) gidx = MW'(i);
    end
  end

  // Round-robin search from rr_ptr+1; rr_ptr equals the current owner, so an
  // owner that re-requests is naturally ranked last.
  always_comb begin
    win_idx   = rr_ptr;
    win_found = 1'b0;
    cand      = '0;
    for (int unsigned i = 1; i <= MASTER_DEVICES; i++) begin
      cand = MW'((32'(rr_ptr) + i) % MASTER_DEVICES);
      if (!win_found && ahb_busreq_in[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  always_comb begin
    in_burst = (ahb_trans_in == TRANS_SEQ) || (ahb_trans_in == TRANS_BUSY);
    do_arb   = 1'b0;
    unique case (state)
      PARK:   do_arb = |ahb_busreq_in;
      OWN:    do_arb = !ahb_lock_in[gidx] &&
                       (!ahb_busreq_in[gidx] ||
                        (ahb_trans_in == TRANS_IDLE) ||
                        ((beat_cnt == CNT_MAX) && !in_burst));
      LOCKED: do_arb = !ahb_lock_in[gidx] && !in_burst;
      default: do_arb = 1'b0;
    endcase
  end

  always_ff @(posedge ahb_clk_in) begin
    if (!ahb_rstn_in) begin
      state               <= PARK;
      ahb_grant_out       <= DEF_GRANT;
      ahb_master_out      <= DEF_IDX;
      ahb_master_data_out <= DEF_IDX;
      ahb_mastlock_out    <= 1'b0;
      beat_cnt            <= '0;
      rr_ptr              <= DEF_IDX;
    end else if (ahb_ready_in) begin
      ahb_master_out      <= gidx;
      ahb_master_data_out <= ahb_master_out;
      ahb_mastlock_out    <= ahb_lock_in[gidx];

      // A new grant (even to the same master) or an owner change restarts the budget.
      if (do_arb || (gidx != ahb_master_out)) begin
        beat_cnt <= '0;
      end else if (ahb_trans_in[1] && (beat_cnt != CNT_MAX)) begin
        beat_cnt <= beat_cnt + 1'b1;
      end

      if (do_arb) begin
        if (win_found) begin
          ahb_grant_out <= MASTER_DEVICES'(1) << win_idx;
          rr_ptr        <= win_idx;
          state         <= ahb_lock_in[win_idx] ? LOCKED : OWN;
        end else begin
          ahb_grant_out <= DEF_GRANT;
          state         <= PARK;
        end
      end else if ((state == OWN) && ahb_lock_in[gidx]) begin
        state <= LOCKED;
      end
    end
  end

endmodule
